// File: rtl/harmonic_scheduler_if.sv
// Handshake and sample bus between the harmonic frame sequencer and the
// per-harmonic position/sine-LUT datapath plus the DAC path.
// The slave modport is the sequencer's view; the master modport is the
// view of whatever drives it (datapath, tick source, DAC sink).
interface harmonic_scheduler_if;
  logic        i_Sample_Tick;
  logic [7:0]  i_Harmonic_Count;
  logic [15:0] i_Level_Decay;
  logic        i_Sample_Ready;
  logic [15:0] i_Sample_Value;
  logic        i_Freq_Too_High;
  logic [7:0]  o_Harmonic;
  logic        o_Next_Sample;
  logic [15:0] o_Sample;
  logic        o_Sample_Valid;
  logic        o_Busy;
  logic        o_Overrun;
  logic        o_Timeout;

  modport slave (
    input  i_Sample_Tick, i_Harmonic_Count, i_Level_Decay,
    input  i_Sample_Ready, i_Sample_Value, i_Freq_Too_High,
    output o_Harmonic, o_Next_Sample, o_Sample, o_Sample_Valid,
    output o_Busy, o_Overrun, o_Timeout
  );

  modport master (
    output i_Sample_Tick, i_Harmonic_Count, i_Level_Decay,
    output i_Sample_Ready, i_Sample_Value, i_Freq_Too_High,
    input  o_Harmonic, o_Next_Sample, o_Sample, o_Sample_Valid,
    input  o_Busy, o_Overrun, o_Timeout
  );
endinterface

// File: rtl/harmonic_scheduler.sv
// Frame sequencer: on each sample tick walks harmonics through the datapath,
// weights each sine value by a geometrically decaying level, accumulates,
// and emits one saturated 16-bit sample per frame.
module harmonic_scheduler #(
  parameter int MAX_HARMONICS = 128,
  parameter int SAMPLE_LAT    = 2,
  parameter int ACC_WIDTH     = 32,
  parameter int OUT_SHIFT     = 2,
  parameter int TIMEOUT       = 255
) (
  input logic                 i_Clock,
  input logic                 i_Reset_n,
  harmonic_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_RDY, S_WAIT_LAT, S_MAC, S_ADVANCE, S_OUTPUT
  } state_t;

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam int LAT_W = (SAMPLE_LAT > 1) ? $clog2(SAMPLE_LAT) : 1;
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT);
  localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(SAMPLE_LAT - 1);
  localparam logic [7:0]       MAX_H8    = 8'(MAX_HARMONICS);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(32767);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = -ACC_WIDTH'(32768);

  state_t                       state_reg;
  logic [7:0]                   count_reg;
  logic [15:0]                  decay_reg;
  logic [15:0]                  level_reg;
  logic signed [ACC_WIDTH-1:0]  acc_reg;
  logic [TMR_W-1:0]             timer_reg;
  logic [LAT_W-1:0]             lat_reg;
  logic signed [15:0]           value_reg;
  logic                         fth_reg;
  logic                         end_reg;
  logic [7:0]                   harmonic_reg;
  logic                         next_reg;
  logic [15:0]                  sample_reg;
  logic                         valid_reg;
  logic                         busy_reg;
  logic                         overrun_reg;
  logic                         timeout_reg;

  logic signed [31:0]           value_ext;
  logic signed [31:0]           level_ext;
  logic signed [31:0]           product;
  logic signed [31:0]           product_scaled;
  logic signed [ACC_WIDTH-1:0]  acc_next;
  logic [31:0]                  level_prod;
  logic [15:0]                  level_next;
  logic                         mac_end;
  logic signed [ACC_WIDTH-1:0]  acc_shifted;
  logic [15:0]                  sat_sample;
  logic [7:0]                   count_clamped;

  // Weighted-sample arithmetic: the level is unsigned, so it is zero-extended
  // before the signed multiply; the 32-bit product cannot overflow.
  always_comb begin
    value_ext      = {{16{value_reg[15]}}, value_reg};
    level_ext      = {16'd0, level_reg};
    product        = value_ext * level_ext;
    product_scaled = product >>> 16;
    acc_next       = acc_reg + ACC_WIDTH'(product_scaled);
    level_prod     = {16'd0, level_reg} * {16'd0, decay_reg};
    level_next     = 16'(level_prod >> 16);
    mac_end        = fth_reg || (harmonic_reg == count_reg - 8'd1) || (level_next == 16'd0);
  end

  // Output scaling and clamp to the signed 16-bit DAC range.
  always_comb begin
    acc_shifted = acc_reg >>> OUT_SHIFT;
    sat_sample  = acc_shifted[15:0];
    if (acc_shifted > SAT_MAX)
      sat_sample = 16'h7FFF;
    else if (acc_shifted < SAT_MIN)
      sat_sample = 16'h8000;
  end

  // Harmonic count at frame start: zero means one harmonic, excess is clamped.
  always_comb begin
    count_clamped = bus.i_Harmonic_Count;
    if (bus.i_Harmonic_Count == 8'd0)
      count_clamped = 8'd1;
    else if (bus.i_Harmonic_Count > MAX_H8)
      count_clamped = MAX_H8;
  end

  // Frame state machine; every output is a register updated here.
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      state_reg    <= S_IDLE;
      count_reg    <= 8'd0;
      decay_reg    <= 16'd0;
      level_reg    <= 16'hFFFF;
      acc_reg      <= '0;
      timer_reg    <= '0;
      lat_reg      <= '0;
      value_reg    <= 16'sd0;
      fth_reg      <= 1'b0;
      end_reg      <= 1'b0;
      harmonic_reg <= 8'd0;
      next_reg     <= 1'b0;
      sample_reg   <= 16'd0;
      valid_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      overrun_reg  <= 1'b0;
      timeout_reg  <= 1'b0;
    end else begin
      next_reg    <= 1'b0;
      valid_reg   <= 1'b0;
      // A tick outside IDLE (OUTPUT included) is dropped and flagged.
      overrun_reg <= bus.i_Sample_Tick && (state_reg != S_IDLE);
      case (state_reg)
        S_IDLE: begin
          if (bus.i_Sample_Tick) begin
            count_reg <= count_clamped;
            decay_reg <= bus.i_Level_Decay;
            acc_reg   <= '0;
            level_reg <= 16'hFFFF;
            end_reg   <= 1'b0;
            timer_reg <= '0;
            busy_reg  <= 1'b1;
            state_reg <= S_WAIT_RDY;
          end
        end
        S_WAIT_RDY: begin
          if (bus.i_Sample_Ready) begin
            timer_reg <= '0;
            lat_reg   <= '0;
            state_reg <= S_WAIT_LAT;
          end else if (timer_reg == TMR_LIMIT) begin
            // Give up on this frame but still release the datapath.
            timeout_reg  <= 1'b1;
            end_reg      <= 1'b1;
            next_reg     <= 1'b1;
            harmonic_reg <= 8'd0;
            timer_reg    <= '0;
            state_reg    <= S_ADVANCE;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        S_WAIT_LAT: begin
          if (lat_reg == LAT_LAST) begin
            value_reg <= bus.i_Sample_Value;
            fth_reg   <= bus.i_Freq_Too_High;
            state_reg <= S_MAC;
          end else begin
            lat_reg <= lat_reg + 1'b1;
          end
        end
        S_MAC: begin
          if (!fth_reg) begin
            acc_reg   <= acc_next;
            level_reg <= level_next;
          end
          // Next_Sample is high throughout ADVANCE while Ready is still up,
          // and the new harmonic index is already on the bus with it.
          end_reg      <= mac_end;
          next_reg     <= 1'b1;
          harmonic_reg <= mac_end ? 8'd0 : harmonic_reg + 8'd1;
          state_reg    <= S_ADVANCE;
        end
        S_ADVANCE: begin
          state_reg <= end_reg ? S_OUTPUT : S_WAIT_RDY;
        end
        S_OUTPUT: begin
          sample_reg <= sat_sample;
          valid_reg  <= 1'b1;
          busy_reg   <= 1'b0;
          state_reg  <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.o_Harmonic     = harmonic_reg;
  assign bus.o_Next_Sample  = next_reg;
  assign bus.o_Sample       = sample_reg;
  assign bus.o_Sample_Valid = valid_reg;
  assign bus.o_Busy         = busy_reg;
  assign bus.o_Overrun      = overrun_reg;
  assign bus.o_Timeout      = timeout_reg;

endmodule

// File: tb/tb_harmonic_scheduler.sv
// Bench for harmonic_scheduler: a small datapath model answers the
// Ready/Next handshake; frames are driven from a vector table, and the
// overrun, timeout and mid-frame reset cases are hand-written sequences.
module tb_harmonic_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  harmonic_scheduler_if dp();

  harmonic_scheduler dut (
    .i_Clock   (clk),
    .i_Reset_n (rst_n),
    .bus       (dp)
  );

  // Datapath model: Ready drops when Next is seen and returns 3 edges later.
  logic               m_ready;
  int                 m_gap;
  logic               never_ready = 1'b0;
  logic signed [15:0] cur_value = 16'sd0;
  int                 fth_idx = -1;

  assign dp.i_Sample_Ready  = m_ready;
  assign dp.i_Sample_Value  = m_ready ? cur_value : 16'd0;
  assign dp.i_Freq_Too_High = m_ready && (int'(dp.o_Harmonic) == fth_idx);

  always @(posedge clk) begin
    if (!rst_n || never_ready) begin
      m_ready <= 1'b0;
      m_gap   <= 2;
    end else if (dp.o_Next_Sample) begin
      m_ready <= 1'b0;
      m_gap   <= 2;
    end else if (!m_ready) begin
      if (m_gap == 0) m_ready <= 1'b1;
      else            m_gap   <= m_gap - 1;
    end
  end

  // Pulse monitors, sampled on the falling edge.
  int next_cnt = 0;
  int valid_cnt = 0;
  int bad_next = 0;
  always @(negedge clk) begin
    if (dp.o_Next_Sample) begin
      next_cnt++;
      if (!m_ready) bad_next++;
    end
    if (dp.o_Sample_Valid) valid_cnt++;
  end

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Wait (bounded) for o_Sample_Valid; lat counts edges since the tick edge.
  task automatic wait_valid(inout int lat);
    while (!dp.o_Sample_Valid && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_frame(input logic [7:0] cnt, input logic [15:0] dec,
                           input logic signed [15:0] val, input int fidx,
                           output int lat, output int nexts);
    int n0;
    @(negedge clk);
    dp.i_Harmonic_Count = cnt;
    dp.i_Level_Decay    = dec;
    cur_value           = val;
    fth_idx             = fidx;
    n0                  = next_cnt;
    dp.i_Sample_Tick    = 1'b1;
    @(negedge clk);
    dp.i_Sample_Tick    = 1'b0;
    lat                 = 1;
    wait_valid(lat);
    nexts = next_cnt - n0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_harmonic"}, dp.o_Harmonic, 0);
    check({tag, "_next"},     dp.o_Next_Sample, 0);
    check({tag, "_sample"},   dp.o_Sample, 0);
    check({tag, "_valid"},    dp.o_Sample_Valid, 0);
    check({tag, "_busy"},     dp.o_Busy, 0);
    check({tag, "_overrun"},  dp.o_Overrun, 0);
    check({tag, "_timeout"},  dp.o_Timeout, 0);
  endtask

  typedef struct {
    logic [7:0]         cnt;
    logic [15:0]        dec;
    logic signed [15:0] val;
    int                 fidx;
    int                 exp_sample;
    int                 exp_nexts;
    int                 exp_lat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int lat, nexts, v0;

    dp.i_Sample_Tick    = 1'b0;
    dp.i_Harmonic_Count = 8'd0;
    dp.i_Level_Decay    = 16'd0;

    // Latency with this model: 8*N-1 edges (N handshakes, 3-edge turnaround).
    vecs[0] = '{8'd1,   16'h0000, 16'sd16384, -1,  4095,   1,    7};
    vecs[1] = '{8'd4,   16'h8000, 16'sd16384, -1,  7679,   4,   31};
    vecs[2] = '{8'd8,   16'h8000, 16'sd16384,  3,  7167,   4,   31};
    vecs[3] = '{8'd16,  16'hFFFF, 16'sd32767, -1,  32767,  16,  127};
    vecs[4] = '{8'd16,  16'hFFFF, 16'h8000,   -1, -32768,  16,  127};
    vecs[5] = '{8'd0,   16'h8000, 16'sd16384, -1,  4095,   1,    7};
    vecs[6] = '{8'd200, 16'hFFFF, 16'sd8,     -1,  224,    128, 1023};
    vecs[7] = '{8'd128, 16'h4000, 16'sd16384, -1,  5459,   8,   63};

    // Reset state.
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_frame(vecs[i].cnt, vecs[i].dec, vecs[i].val, vecs[i].fidx, lat, nexts);
      $display("frame %0d: count=%0d decay=%h value=%0d -> sample=%0d nexts=%0d latency=%0d",
               i, vecs[i].cnt, vecs[i].dec, vecs[i].val, $signed(dp.o_Sample), nexts, lat);
      check($sformatf("v%0d_valid_seen", i), dp.o_Sample_Valid, 1);
      check($sformatf("v%0d_sample", i), longint'($signed(dp.o_Sample)), vecs[i].exp_sample);
      check($sformatf("v%0d_nexts", i), nexts, vecs[i].exp_nexts);
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_harmonic_end", i), dp.o_Harmonic, 0);
      check($sformatf("v%0d_busy_end", i), dp.o_Busy, 0);
      @(negedge clk);
      check($sformatf("v%0d_valid_once", i), dp.o_Sample_Valid, 0);
      repeat (4) @(negedge clk);
    end
    check("next_only_when_ready", bad_next, 0);
    check("timeout_clear", dp.o_Timeout, 0);

    // Second tick mid-frame: overrun pulse, frame result unchanged.
    @(negedge clk);
    dp.i_Harmonic_Count = 8'd4;
    dp.i_Level_Decay    = 16'h8000;
    cur_value           = 16'sd16384;
    fth_idx             = -1;
    v0                  = next_cnt;
    dp.i_Sample_Tick    = 1'b1;
    @(negedge clk);
    dp.i_Sample_Tick = 1'b0;
    check("ovr_busy", dp.o_Busy, 1);
    repeat (3) @(negedge clk);
    dp.i_Sample_Tick = 1'b1;
    @(negedge clk);
    dp.i_Sample_Tick = 1'b0;
    check("ovr_pulse", dp.o_Overrun, 1);
    @(negedge clk);
    check("ovr_one_cycle", dp.o_Overrun, 0);
    lat = 6;
    wait_valid(lat);
    $display("overrun frame: sample=%0d nexts=%0d latency=%0d", $signed(dp.o_Sample), next_cnt - v0, lat);
    check("ovr_sample", longint'($signed(dp.o_Sample)), 7679);
    check("ovr_nexts", next_cnt - v0, 4);
    check("ovr_latency", lat, 31);
    repeat (5) @(negedge clk);

    // Tick on the OUTPUT cycle of a one-harmonic frame.
    dp.i_Harmonic_Count = 8'd1;
    dp.i_Level_Decay    = 16'h0000;
    dp.i_Sample_Tick    = 1'b1;
    @(negedge clk);
    dp.i_Sample_Tick = 1'b0;
    repeat (5) @(negedge clk);
    dp.i_Sample_Tick = 1'b1;
    @(negedge clk);
    dp.i_Sample_Tick = 1'b0;
    $display("tick on output cycle: valid=%0d overrun=%0d sample=%0d",
             dp.o_Sample_Valid, dp.o_Overrun, $signed(dp.o_Sample));
    check("outcyc_valid", dp.o_Sample_Valid, 1);
    check("outcyc_overrun", dp.o_Overrun, 1);
    check("outcyc_sample", longint'($signed(dp.o_Sample)), 4095);
    repeat (3) @(negedge clk);
    check("outcyc_no_new_frame", dp.o_Busy, 0);

    // Datapath never ready: timeout aborts the frame.
    never_ready = 1'b1;
    repeat (3) @(negedge clk);
    run_frame(8'd4, 16'h8000, 16'sd16384, -1, lat, nexts);
    $display("timeout frame: sample=%0d nexts=%0d latency=%0d timeout=%0d",
             $signed(dp.o_Sample), nexts, lat, dp.o_Timeout);
    check("to_valid_seen", dp.o_Sample_Valid, 1);
    check("to_flag", dp.o_Timeout, 1);
    check("to_sample", longint'($signed(dp.o_Sample)), 0);
    check("to_nexts", nexts, 1);
    check("to_latency", lat, 259);
    check("to_harmonic", dp.o_Harmonic, 0);
    repeat (5) @(negedge clk);
    check("to_sticky", dp.o_Timeout, 1);

    // Reset in the middle of a frame: everything cleared, no Valid.
    dp.i_Sample_Tick = 1'b1;
    @(negedge clk);
    dp.i_Sample_Tick = 1'b0;
    repeat (20) @(negedge clk);
    check("mid_busy_before_reset", dp.o_Busy, 1);
    rst_n = 1'b0;
    v0 = valid_cnt;
    @(negedge clk);
    check_reset_outputs("midreset");
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    $display("mid-frame reset: valid pulses after reset=%0d busy=%0d", valid_cnt - v0, dp.o_Busy);
    check("midreset_no_valid", valid_cnt - v0, 0);
    check("midreset_idle", dp.o_Busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
